// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  // Multiply/divide unit occupancy states
  typedef enum logic [1:0] {
    MdIdle,
    MdBusy,
    MdDone
  } md_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side signal bundle for the hazard controller.
// master: pipeline datapath (drives instruction/stage info, receives controls).
// slave:  hazard controller.
interface pipeline_hazard_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic [REG_W-1:0] rs_D;
  logic [REG_W-1:0] rt_D;
  logic             branch_D;
  logic             jump_D;
  logic             pc_src_D;
  logic             md_op_D;
  logic             hilo_read_D;
  logic [REG_W-1:0] write_reg_E;
  logic             reg_write_E;
  logic             mem_to_reg_E;
  logic             md_start_E;
  logic             md_is_div_E;
  logic [REG_W-1:0] write_reg_M;
  logic             reg_write_M;
  logic             mem_to_reg_M;

  logic             stall_F;
  logic             stall_D;
  logic             flush_D;
  logic             flush_E;
  logic             forward_a_D;
  logic             forward_b_D;
  logic             md_busy;
  logic             md_done;
  logic [31:0]      stall_cycles;

  modport master (
    output rs_D, rt_D, branch_D, jump_D, pc_src_D, md_op_D, hilo_read_D,
    output write_reg_E, reg_write_E, mem_to_reg_E, md_start_E, md_is_div_E,
    output write_reg_M, reg_write_M, mem_to_reg_M,
    input  stall_F, stall_D, flush_D, flush_E, forward_a_D, forward_b_D,
    input  md_busy, md_done, stall_cycles
  );

  modport slave (
    input  rs_D, rt_D, branch_D, jump_D, pc_src_D, md_op_D, hilo_read_D,
    input  write_reg_E, reg_write_E, mem_to_reg_E, md_start_E, md_is_div_E,
    input  write_reg_M, reg_write_M, mem_to_reg_M,
    output stall_F, stall_D, flush_D, flush_E, forward_a_D, forward_b_D,
    output md_busy, md_done, stall_cycles
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_md_sequencer.sv
// md_sequencer: tracks occupancy of the multi-cycle mult/div unit.
// IDLE -> BUSY for LATENCY cycles -> DONE (one-cycle md_done) -> IDLE.
module md_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 4,
  parameter int unsigned DIV_LATENCY = 32,
  parameter int unsigned CNT_W       = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic md_start_E,
  input  logic md_is_div_E,
  output logic md_busy,
  output logic md_done
);

  localparam logic [CNT_W-1:0] MulLoad = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] DivLoad = CNT_W'(DIV_LATENCY - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and latency counter registers; reset aborts any in-flight op
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MdIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter update; md_start_E outside IDLE is ignored
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MdIdle: begin
        if (md_start_E) begin
          state_d = MdBusy;
          cnt_d   = md_is_div_E ? DivLoad : MulLoad;
        end
      end
      MdBusy: begin
        if (cnt_q == '0) begin
          state_d = MdDone;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      MdDone:  state_d = MdIdle;
      default: state_d = MdIdle;
    endcase
  end

  // Busy covers the start cycle so a dependent ID instruction stalls at once
  always_comb begin
    md_busy = md_start_E | (state_q != MdIdle);
    md_done = (state_q == MdDone);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline.
// Load-use and branch-in-ID hazard detection, ID branch-comparator forwarding,
// mult/div occupancy sequencing and pipeline stall/flush generation.
// Optional macro HAZ_PERF_CNT_EN: enables the saturating stall_cycles counter;
// otherwise stall_cycles is tied to zero.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 4,
  parameter int unsigned DIV_LATENCY = 32,
  parameter int unsigned CNT_W       = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.slave  bus
);

  logic md_busy;
  logic md_done;

  md_sequencer #(
    .MUL_LATENCY (MUL_LATENCY),
    .DIV_LATENCY (DIV_LATENCY),
    .CNT_W       (CNT_W)
  ) u_md_sequencer (
    .clk         (clk),
    .rst         (rst),
    .md_start_E  (bus.md_start_E),
    .md_is_div_E (bus.md_is_div_E),
    .md_busy     (md_busy),
    .md_done     (md_done)
  );

  logic e_hit_rs, e_hit_rt, m_hit_rs, m_hit_rt;
  logic lw_stall, branch_stall, md_stall, stall;

  // Source/destination matches; $0 never produces a hazard or a forward
  always_comb begin
    e_hit_rs = (bus.write_reg_E != REG_ZERO) && (bus.write_reg_E == bus.rs_D);
    e_hit_rt = (bus.write_reg_E != REG_ZERO) && (bus.write_reg_E == bus.rt_D);
    m_hit_rs = (bus.write_reg_M != REG_ZERO) && (bus.write_reg_M == bus.rs_D);
    m_hit_rt = (bus.write_reg_M != REG_ZERO) && (bus.write_reg_M == bus.rt_D);
  end

  // Hazard detection and pipeline control; a stall overrides a redirect
  always_comb begin
    lw_stall     = bus.mem_to_reg_E & bus.reg_write_E & (e_hit_rs | e_hit_rt);
    branch_stall = bus.branch_D &
                   ((bus.reg_write_E & (e_hit_rs | e_hit_rt)) |
                    (bus.mem_to_reg_M & (m_hit_rs | m_hit_rt)));
    md_stall     = md_busy & (bus.md_op_D | bus.hilo_read_D);
    stall        = lw_stall | branch_stall | md_stall;

    bus.stall_F     = stall;
    bus.stall_D     = stall;
    bus.flush_E     = stall;
    bus.flush_D     = (bus.pc_src_D | bus.jump_D) & ~stall;
    bus.forward_a_D = bus.reg_write_M & m_hit_rs;
    bus.forward_b_D = bus.reg_write_M & m_hit_rt;
    bus.md_busy     = md_busy;
    bus.md_done     = md_done;
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles spent with ID held
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_cycles = stall_cnt_q;
`else
  assign bus.stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, table-driven bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned MulLat = 4;
  localparam int unsigned DivLat = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if hz ();

  pipeline_hazard_ctrl #(
    .MUL_LATENCY (MulLat),
    .DIV_LATENCY (DivLat),
    .CNT_W       (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (hz)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    string      name;
    logic [4:0] rs, rt;
    logic       branch, jump, pc_src, md_op, hilo;
    logic [4:0] wr_e;
    logic       rw_e, m2r_e;
    logic [4:0] wr_m;
    logic       rw_m, m2r_m;
    logic       exp_stall, exp_flush_d, exp_fa, exp_fb;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    hz.rs_D = '0; hz.rt_D = '0; hz.branch_D = 0; hz.jump_D = 0; hz.pc_src_D = 0;
    hz.md_op_D = 0; hz.hilo_read_D = 0; hz.write_reg_E = '0; hz.reg_write_E = 0;
    hz.mem_to_reg_E = 0; hz.md_start_E = 0; hz.md_is_div_E = 0; hz.write_reg_M = '0;
    hz.reg_write_M = 0; hz.mem_to_reg_M = 0;
  endtask

  // Occupancy model: a new start is only legal while the MD unit is free
  int md_left = 0;
  always @(posedge clk) begin
    if (rst) begin
      md_left <= 0;
    end else if (hz.md_start_E && md_left == 0) begin
      md_left <= (hz.md_is_div_E ? DivLat : MulLat) + 1;
    end else begin
      if (hz.md_start_E) begin
        assert (md_left == 0) else $error("md_start_E issued while MD unit occupied");
      end
      if (md_left > 0) md_left <= md_left - 1;
    end
  end

  initial begin
    int   lat;
    logic done_seen;

    //          name           rs  rt  br j  pc md hl wrE rwE m2E wrM rwM m2M  st fD fa fb
    vecs[0]  = '{"idle",        0,  0, 0, 0, 0, 0, 0,  0, 0,  0,  0, 0,  0,   0, 0, 0, 0};
    vecs[1]  = '{"lw_rs",       2,  0, 0, 0, 0, 0, 0,  2, 1,  1,  0, 0,  0,   1, 0, 0, 0};
    vecs[2]  = '{"lw_r0",       0,  0, 0, 0, 0, 0, 0,  0, 1,  1,  0, 0,  0,   0, 0, 0, 0};
    vecs[3]  = '{"lw_rt",       1,  5, 0, 0, 0, 0, 0,  5, 1,  1,  0, 0,  0,   1, 0, 0, 0};
    vecs[4]  = '{"lw_nomatch",  1,  2, 0, 0, 0, 0, 0,  5, 1,  1,  0, 0,  0,   0, 0, 0, 0};
    vecs[5]  = '{"br_fwd_a",    3,  0, 1, 0, 0, 0, 0,  0, 0,  0,  3, 1,  0,   0, 0, 1, 0};
    vecs[6]  = '{"br_ld_m",     3,  0, 1, 0, 0, 0, 0,  0, 0,  0,  3, 1,  1,   1, 0, 1, 0};
    vecs[7]  = '{"br_alu_e",    0,  4, 1, 0, 0, 0, 0,  4, 1,  0,  0, 0,  0,   1, 0, 0, 0};
    vecs[8]  = '{"nobr_alu_e",  0,  4, 0, 0, 0, 0, 0,  4, 1,  0,  0, 0,  0,   0, 0, 0, 0};
    vecs[9]  = '{"fwd_b",       0,  7, 0, 0, 0, 0, 0,  0, 0,  0,  7, 1,  0,   0, 0, 0, 1};
    vecs[10] = '{"fwd_r0",      0,  0, 1, 0, 0, 0, 0,  0, 0,  0,  0, 1,  1,   0, 0, 0, 0};
    vecs[11] = '{"pcsrc",       0,  0, 0, 0, 1, 0, 0,  0, 0,  0,  0, 0,  0,   0, 1, 0, 0};
    vecs[12] = '{"pcsrc_lw",    2,  0, 0, 0, 1, 0, 0,  2, 1,  1,  0, 0,  0,   1, 0, 0, 0};
    vecs[13] = '{"jump",        0,  0, 0, 1, 0, 0, 0,  0, 0,  0,  0, 0,  0,   0, 1, 0, 0};
    vecs[14] = '{"mdop_idle",   0,  0, 0, 0, 0, 1, 1,  0, 0,  0,  0, 0,  0,   0, 0, 0, 0};
    vecs[15] = '{"br_nowrite",  6,  0, 1, 0, 0, 0, 0,  6, 0,  1,  0, 0,  0,   0, 0, 0, 0};

    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_md_busy", 32'(hz.md_busy), 0);
    check("reset_md_done", 32'(hz.md_done), 0);
    check("reset_stall_cycles", hz.stall_cycles, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      hz.rs_D = vecs[i].rs; hz.rt_D = vecs[i].rt; hz.branch_D = vecs[i].branch;
      hz.jump_D = vecs[i].jump; hz.pc_src_D = vecs[i].pc_src; hz.md_op_D = vecs[i].md_op;
      hz.hilo_read_D = vecs[i].hilo; hz.write_reg_E = vecs[i].wr_e;
      hz.reg_write_E = vecs[i].rw_e; hz.mem_to_reg_E = vecs[i].m2r_e;
      hz.write_reg_M = vecs[i].wr_m; hz.reg_write_M = vecs[i].rw_m;
      hz.mem_to_reg_M = vecs[i].m2r_m;
      #1;
      check({vecs[i].name, ".stall_F"}, 32'(hz.stall_F), 32'(vecs[i].exp_stall));
      check({vecs[i].name, ".stall_D"}, 32'(hz.stall_D), 32'(vecs[i].exp_stall));
      check({vecs[i].name, ".flush_E"}, 32'(hz.flush_E), 32'(vecs[i].exp_stall));
      check({vecs[i].name, ".flush_D"}, 32'(hz.flush_D), 32'(vecs[i].exp_flush_d));
      check({vecs[i].name, ".fwd_a"}, 32'(hz.forward_a_D), 32'(vecs[i].exp_fa));
      check({vecs[i].name, ".fwd_b"}, 32'(hz.forward_b_D), 32'(vecs[i].exp_fb));
    end

    // Multiply: busy 4 cycles after start, md_done in cycle 5, mfhi stalls through DONE
    @(negedge clk);
    clear_inputs();
    hz.md_start_E = 1; hz.md_is_div_E = 0; hz.hilo_read_D = 1;
    #1;
    check("mul.c0.busy", 32'(hz.md_busy), 1);
    check("mul.c0.stall", 32'(hz.stall_D), 1);
    check("mul.c0.done", 32'(hz.md_done), 0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      hz.md_start_E = 0;
      #1;
      check($sformatf("mul.c%0d.busy", c), 32'(hz.md_busy), 32'(c <= 5));
      check($sformatf("mul.c%0d.done", c), 32'(hz.md_done), 32'(c == 5));
      check($sformatf("mul.c%0d.stall", c), 32'(hz.stall_D), 32'(c <= 5));
    end
    hz.hilo_read_D = 0;

    // Divide aborted by reset on its third BUSY cycle
    @(negedge clk);
    hz.md_start_E = 1; hz.md_is_div_E = 1;
    @(negedge clk);
    hz.md_start_E = 0; hz.md_is_div_E = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort.busy_in_rst", 32'(hz.md_busy), 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort.busy_after", 32'(hz.md_busy), 0);
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (hz.md_done) done_seen = 1;
    end
    check("abort.no_done", 32'(done_seen), 0);

    // Fresh multiply after the abort completes normally
    @(negedge clk);
    hz.md_start_E = 1; hz.md_is_div_E = 0;
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      hz.md_start_E = 0;
      #1;
      if (hz.md_done && lat < 0) lat = c;
    end
    check("post_abort.mul_latency", 32'(lat), 32'(MulLat + 1));

    // Perf counter: 7 load-use stall cycles
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    #1;
    check("perf.after_reset", hz.stall_cycles, 0);
    hz.mem_to_reg_E = 1; hz.reg_write_E = 1; hz.write_reg_E = 9; hz.rs_D = 9;
    repeat (7) @(negedge clk);
    clear_inputs();
    @(negedge clk);
    #1;
`ifdef HAZ_PERF_CNT_EN
    check("perf.count", hz.stall_cycles, 7);
`else
    check("perf.count", hz.stall_cycles, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
